waveform_buffer: RTL and testbench
==================================

WAVEFORM_BUFFER -- requirements
Module: waveform_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 512, meaning FIFO depth in 256-bit words (power of 2, at least 4).
REQ-002 SHALL have port clk, input, 1 bit: the 250 MHz RFSoC IP clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port load_tdata, input, 256 bits: waveform words written by the PS.
REQ-005 SHALL have port load_tvalid, input, 1 bit: load word valid.
REQ-006 SHALL have port load_tready, output, 1 bit: load word accepted.
REQ-007 SHALL have port loop_tdata, input, 256 bits: the DAC controller's output word, fed back for recirculation.
REQ-008 SHALL have port loop_valid, input, 1 bit: the DAC controller's loopback-valid flag.
REQ-009 SHALL have port mux_sel, input, 1 bit: write-source select; 0 = load, 1 = loopback.
REQ-010 SHALL have port flush, input, 1 bit: synchronous clear.
REQ-011 SHALL have port m_axis_tdata, output, 256 bits: head-of-FIFO word sent to the DAC controller.
REQ-012 SHALL have port m_axis_tvalid, output, 1 bit: head word valid.
REQ-013 SHALL have port m_axis_tready, input, 1 bit: DAC controller is consuming.
REQ-014 SHALL have port fill_level, output, clog2(DEPTH)+1 bits: number of stored words.
REQ-015 SHALL have port overflow, output, 1 bit: sticky flag for a dropped loopback word.

Function
REQ-016 SHALL define full as fill_level==DEPTH and empty as fill_level==0.
REQ-017 SHALL drive load_tready = !full && !mux_sel, combinationally.
REQ-018 SHALL perform a write when mux_sel=0 and load_tvalid && load_tready; loop_valid is ignored in this mode.
REQ-019 SHALL perform a write when mux_sel=1 and loop_valid && (!full || rd); load_tvalid is ignored in this mode.
REQ-020 SHALL define rd = m_axis_tvalid && m_axis_tready.
REQ-021 SHALL drop the word and set overflow on the next edge when mux_sel=1, loop_valid=1, full and !rd.
REQ-022 SHALL act on mux_sel in the same cycle it changes, with no pipelining of the select.
REQ-023 SHALL present the FIFO in first-word-fall-through form: m_axis_tvalid = !empty, and m_axis_tdata = the oldest word whenever tvalid=1.
REQ-024 SHALL make a word written on edge N visible on m_axis_tvalid/tdata after edge N (zero-bubble latency of 1 clock); a write into an empty FIFO does not bypass the storage in the same cycle.
REQ-025 SHALL ignore m_axis_tready while empty, with no pointer change and no underflow.
REQ-026 SHALL handle a simultaneous write and read by leaving fill_level unchanged and advancing both pointers.
REQ-027 SHALL otherwise update fill_level by +1 on a write alone and -1 on a read alone.
REQ-028 SHALL wrap read and write pointers modulo DEPTH, keeping data order across the wrap.
REQ-029 SHALL make m_axis_tdata a don't-care while tvalid=0, though the bench expects a stable value.
REQ-030 SHALL give flush=1 priority over write and read: on that edge, pointers and fill_level go to 0 and overflow is cleared.
REQ-031 SHALL NOT write or read the same-cycle word during a flush.
REQ-032 SHALL keep overflow set until flush or reset.
REQ-033 SHALL support a recirculation steady state: with mux_sel=1 and loopback carrying the words the DAC controller read, fill_level holds constant at its preloaded value across repeated playback cycles.

Reset
REQ-034 SHALL, on rst=0, asynchronously clear pointers, fill_level and overflow, independent of clk.
REQ-035 SHALL hold m_axis_tvalid=0 and load_tready=!mux_sel while in reset or after reset release.
REQ-036 SHALL leave storage contents uninitialised, since they are not observable while empty.
REQ-037 SHALL, on rst assertion mid-write or mid-read, lose the in-flight word and return to empty.
REQ-038 SHALL permit the first write on the first clk edge after rst deassertion.

Verification
REQ-039 SHALL cover a load then drain: mux_sel=0, write 0x1..0x8 -> fill_level=8, then tready=1 -> reads 0x1..0x8 in order, tvalid falls after the 8th read.
REQ-040 SHALL cover fill to full: DEPTH load writes -> load_tready=0, and a 513th load_tvalid is not accepted with no data change.
REQ-041 SHALL cover loopback at full: preload DEPTH words, mux_sel=1, loop_valid=1 with tready=1 -> fill_level stays at DEPTH, overflow=0, and words recirculate in order.
REQ-042 SHALL cover overflow: full, mux_sel=1, loop_valid=1, tready=0 for 1 cycle -> overflow=1 and fill_level=DEPTH; then flush -> overflow=0, fill_level=0, tvalid=0.
REQ-043 SHALL cover pointer wrap: 3*DEPTH/2 interleaved writes and reads with an incrementing pattern -> no missing or duplicated word.
REQ-044 SHALL cover reset mid-stream: fill_level=5, assert rst between edges -> fill_level=0 and tvalid=0 immediately; after release, one write of 0xA5 -> tvalid=1 and tdata=0xA5 next cycle.

Source files
------------

// File: rtl/waveform_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : waveform_buffer
//  Purpose  : First-word-fall-through waveform FIFO feeding the DAC
//             controller. Words are written either from the PS load stream
//             or from the DAC controller's loopback path, which lets a
//             preloaded waveform recirculate indefinitely.
//  Ports    : clk            - 250 MHz RFSoC IP clock, rising edge
//             rst            - asynchronous active-low reset
//             load_tdata/tvalid/tready - PS load stream (mux_sel = 0)
//             loop_tdata/loop_valid    - loopback word (mux_sel = 1)
//             mux_sel        - write-source select, 0 = load, 1 = loopback
//             flush          - synchronous clear, wins over read and write
//             m_axis_tdata/tvalid/tready - head-of-FIFO output stream
//             fill_level     - number of stored words
//             overflow       - sticky: a loopback word was dropped
//  Revision : 1.0 - initial release
// ============================================================================
module waveform_buffer #(
    parameter int DEPTH = 512
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [255:0]             load_tdata,
    input  logic                     load_tvalid,
    output logic                     load_tready,
    input  logic [255:0]             loop_tdata,
    input  logic                     loop_valid,
    input  logic                     mux_sel,
    input  logic                     flush,
    output logic [255:0]             m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [$clog2(DEPTH):0]   fill_level,
    output logic                     overflow
);

    localparam int             AW     = $clog2(DEPTH);
    localparam logic [AW:0]    C_FULL = (AW+1)'(DEPTH);

    // Storage carries no reset: contents are unobservable while empty.
    logic [255:0]   mem [DEPTH];

    logic [AW-1:0]  wptr_q, wptr_d;
    logic [AW-1:0]  rptr_q, rptr_d;
    logic [AW:0]    fill_q, fill_d;
    logic           ovf_q,  ovf_d;

    logic           full;
    logic           empty;
    logic           rd;
    logic           wr;
    logic           drop;
    logic [255:0]   wdata;

    assign full          = (fill_q == C_FULL);
    assign empty         = (fill_q == '0);
    assign load_tready   = !full && !mux_sel;
    assign m_axis_tvalid = !empty;
    assign rd            = m_axis_tvalid && m_axis_tready;

    // A loopback word may enter a full FIFO when the head leaves in the same
    // cycle; that is what keeps recirculation lossless at full depth.
    assign wr    = mux_sel ? (loop_valid && (!full || rd))
                           : (load_tvalid && load_tready);
    assign drop  = mux_sel && loop_valid && full && !rd;
    assign wdata = mux_sel ? loop_tdata : load_tdata;

    // Head word read straight from storage gives first-word-fall-through.
    // When full with a simultaneous read and write, wptr == rptr: the old
    // head is presented this cycle and overwritten at the edge.
    assign m_axis_tdata = mem[rptr_q];
    assign fill_level   = fill_q;
    assign overflow     = ovf_q;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        fill_d = fill_q;
        ovf_d  = ovf_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
            fill_d = '0;
            ovf_d  = 1'b0;
        end else begin
            if (wr) begin
                wptr_d = wptr_q + 1'b1;
            end
            if (rd) begin
                rptr_d = rptr_q + 1'b1;
            end
            if (wr && !rd) begin
                fill_d = fill_q + 1'b1;
            end else if (rd && !wr) begin
                fill_d = fill_q - 1'b1;
            end
            if (drop) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            fill_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            fill_q <= fill_d;
            ovf_q  <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr && !flush) begin
            mem[wptr_q] <= wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_waveform_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_waveform_buffer
//  Purpose  : Self-checking bench for waveform_buffer. A queue-based model
//             tracks the stored words and the sticky overflow bit; every
//             cycle the DUT outputs are compared against it.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_waveform_buffer;

    localparam int DEPTH = 512;
    localparam int FW    = $clog2(DEPTH) + 1;

    logic           clk = 1'b0;
    logic           rst;
    logic [255:0]   load_tdata;
    logic           load_tvalid;
    logic           load_tready;
    logic [255:0]   loop_tdata;
    logic           loop_valid;
    logic           mux_sel;
    logic           flush;
    logic [255:0]   m_axis_tdata;
    logic           m_axis_tvalid;
    logic           m_axis_tready;
    logic [FW-1:0]  fill_level;
    logic           overflow;

    int             checks = 0;
    int             errors = 0;

    logic [255:0]   model_q [$];
    logic           model_ovf = 1'b0;

    waveform_buffer #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .load_tdata    (load_tdata),
        .load_tvalid   (load_tvalid),
        .load_tready   (load_tready),
        .loop_tdata    (loop_tdata),
        .loop_valid    (loop_valid),
        .mux_sel       (mux_sel),
        .flush         (flush),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .fill_level    (fill_level),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every visible output against the model's current contents.
    task automatic check_outputs(input string tag);
        int  n;
        n = model_q.size();
        chk({tag, ":fill"},     256'(fill_level),    256'(n));
        chk({tag, ":tvalid"},   256'(m_axis_tvalid), 256'(n != 0));
        chk({tag, ":tready"},   256'(load_tready),   256'((n != DEPTH) && !mux_sel));
        chk({tag, ":overflow"}, 256'(overflow),      256'(model_ovf));
        if (n != 0) begin
            chk({tag, ":tdata"}, m_axis_tdata, model_q[0]);
        end
    endtask

    // One clock: apply inputs, check outputs before the edge, advance model.
    task automatic cycle(input string tag, input logic ms, input logic ldv,
                         input logic [255:0] ld, input logic lpv,
                         input logic [255:0] lp, input logic tr, input logic fl);
        int   n;
        logic take_rd, take_wr, lost;
        mux_sel       = ms;
        load_tvalid   = ldv;
        load_tdata    = ld;
        loop_valid    = lpv;
        loop_tdata    = lp;
        m_axis_tready = tr;
        flush         = fl;
        #1;
        check_outputs(tag);
        n       = model_q.size();
        take_rd = (n != 0) && tr;
        take_wr = ms ? (lpv && ((n != DEPTH) || take_rd)) : (ldv && (n != DEPTH));
        lost    = ms && lpv && (n == DEPTH) && !take_rd;
        if (fl) begin
            model_q.delete();
            model_ovf = 1'b0;
        end else begin
            if (take_rd) void'(model_q.pop_front());
            if (take_wr) model_q.push_back(ms ? lp : ld);
            if (lost) model_ovf = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [255:0] rnd256();
        return {$urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [255:0] head;
        rst           = 1'b0;
        mux_sel       = 1'b0;
        load_tvalid   = 1'b0;
        load_tdata    = '0;
        loop_valid    = 1'b0;
        loop_tdata    = '0;
        m_axis_tready = 1'b0;
        flush         = 1'b0;

        // Reset state, with load_tready following mux_sel during reset.
        #1;
        check_outputs("reset");
        mux_sel = 1'b1;
        #1;
        chk("reset:tready_sel1", 256'(load_tready), 256'(0));
        mux_sel = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Load 1..8, then drain in order.
        for (int i = 1; i <= 8; i++) cycle("load8", 0, 1, 256'(i), 0, '0, 0, 0);
        for (int i = 0; i < 8; i++)  cycle("drain8", 0, 0, '0, 0, '0, 1, 0);
        cycle("drained", 0, 0, '0, 0, '0, 1, 0);

        // Fill to full, then a rejected extra load word.
        for (int i = 0; i < DEPTH; i++) cycle("fill", 0, 1, 256'(32'h1000 + i), 0, '0, 0, 0);
        cycle("extra_load", 0, 1, 256'hDEAD, 0, '0, 0, 0);
        cycle("extra_load2", 0, 1, 256'hBEEF, 0, '0, 0, 0);

        // Recirculation at full depth: loopback carries the word being read.
        for (int i = 0; i < 2 * DEPTH; i++) begin
            head = model_q[0];
            cycle("recirc", 1, 0, '0, 1, head, 1, 0);
        end

        // Overflow: full, loopback word with no read -> dropped, sticky flag.
        cycle("ovf_drop", 1, 0, '0, 1, 256'h5A5A, 0, 0);
        cycle("ovf_hold", 1, 0, '0, 0, '0, 0, 0);
        cycle("flush", 0, 1, 256'h77, 0, '0, 1, 1);
        cycle("after_flush", 0, 0, '0, 0, '0, 0, 0);

        // Pointer wrap: 3*DEPTH/2 incrementing writes with interleaved reads.
        for (int i = 0; i < 3 * DEPTH / 2; i++)
            cycle("wrap", 0, 1, 256'(i), 0, '0, ($urandom_range(0, 3) != 0), 0);
        while (model_q.size() != 0) cycle("wrap_drain", 0, 0, '0, 0, '0, 1, 0);

        // Asynchronous reset mid-stream at fill level 5.
        for (int i = 0; i < 5; i++) cycle("pre_rst", 0, 1, 256'(i + 40), 0, '0, 0, 0);
        load_tvalid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        model_q.delete();
        model_ovf = 1'b0;
        chk("rst_async:fill",   256'(fill_level),    256'(0));
        chk("rst_async:tvalid", 256'(m_axis_tvalid), 256'(0));
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        cycle("post_rst_wr", 0, 1, 256'hA5, 0, '0, 0, 0);
        chk("post_rst:tvalid", 256'(m_axis_tvalid), 256'(1));
        chk("post_rst:tdata",  m_axis_tdata,        256'hA5);
        cycle("post_rst_rd", 0, 0, '0, 0, '0, 1, 0);

        // Randomized traffic over both sources, reads and occasional flushes.
        for (int i = 0; i < 3000; i++) begin
            cycle("random", 1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7), rnd256(),
                  ($urandom_range(0, 9) < 7), rnd256(), 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 199) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
